// File: rtl/hazard_controller_if.sv
// hazard_controller_if: pipeline-side register specifiers/control bits and the controller's steering outputs.
interface hazard_controller_if;
    logic [3:0] id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2, id_use_r0, branch_taken;
    logic [3:0] ex_rd, m_rd, wb_rd;
    logic [1:0] ex_reg_write, m_reg_write, wb_reg_write;
    logic       ex_mem_read, m_mem_read, ex_multidiv;
    logic       pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exm_bubble;
    logic [1:0] op1_fwd, op2_fwd, r0_fwd;
    logic       md_busy;
    logic [3:0] md_count;
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_use_r0, branch_taken,
        output ex_rd, m_rd, wb_rd, ex_reg_write, m_reg_write, wb_reg_write,
        output ex_mem_read, m_mem_read, ex_multidiv,
        input  pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exm_bubble,
        input  op1_fwd, op2_fwd, r0_fwd, md_busy, md_count
    );
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_use_r0, branch_taken,
        input  ex_rd, m_rd, wb_rd, ex_reg_write, m_reg_write, wb_reg_write,
        input  ex_mem_read, m_mem_read, ex_multidiv,
        output pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exm_bubble,
        output op1_fwd, op2_fwd, r0_fwd, md_busy, md_count
    );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: ID-stage forwarding selects, load-use stall, branch flush and multiply/divide hold sequencing.
module hazard_controller #(
    parameter int MD_CYCLES = 4
) (
    input logic clk,
    input logic reset,
    hazard_controller_if.slave hz
);
    typedef enum logic {RUN, MD_BUSY} state_t;
    state_t state, state_next;
    logic [3:0] count, count_next;
    logic hold, stall;
    logic ex1, m1, wb1, ex2, m2, wb2, exr, mr, wbr;
    function automatic logic [1:0] sel(input logic en, input logic ex, input logic m, input logic wb);
        return !en ? 2'b00 : ex ? 2'b01 : m ? 2'b10 : wb ? 2'b11 : 2'b00;
    endfunction
    always_comb begin
        ex1 = hz.ex_reg_write[0] && hz.ex_rd == hz.id_rs1;
        m1  = hz.m_reg_write[0]  && hz.m_rd  == hz.id_rs1;
        wb1 = hz.wb_reg_write[0] && hz.wb_rd == hz.id_rs1;
        ex2 = hz.ex_reg_write[0] && hz.ex_rd == hz.id_rs2;
        m2  = hz.m_reg_write[0]  && hz.m_rd  == hz.id_rs2;
        wb2 = hz.wb_reg_write[0] && hz.wb_rd == hz.id_rs2;
        exr = hz.ex_reg_write[1] || (hz.ex_reg_write[0] && hz.ex_rd == 4'd0);
        mr  = hz.m_reg_write[1]  || (hz.m_reg_write[0]  && hz.m_rd  == 4'd0);
        wbr = hz.wb_reg_write[1] || (hz.wb_reg_write[0] && hz.wb_rd == 4'd0);
        // M-stage forwarding carries a load's address, so loads in EX and M both stall
        stall = (hz.id_use_rs1 && ((ex1 && hz.ex_mem_read) || (m1 && hz.m_mem_read)))
             || (hz.id_use_rs2 && ((ex2 && hz.ex_mem_read) || (m2 && hz.m_mem_read)))
             || (hz.id_use_r0  && ((exr && hz.ex_mem_read) || (mr && hz.m_mem_read)));
    end
    always_comb begin
        state_next = state;
        count_next = count;
        hold = 1'b0;
        if (state == RUN) begin
            hold = hz.ex_multidiv;
            count_next = hz.ex_multidiv ? 4'(MD_CYCLES - 2) : 4'd0;
            state_next = hz.ex_multidiv ? MD_BUSY : RUN;
        end else begin
            hold = count != 4'd0;
            count_next = hold ? count - 4'd1 : 4'd0;
            state_next = hold ? MD_BUSY : RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end
    always_comb begin
        hz.pc_write    = reset || !(hold || stall);
        hz.ifid_write  = reset || !(hold || stall);
        hz.idex_write  = reset || !hold;
        hz.idex_bubble = !reset && !hold && stall;
        hz.exm_bubble  = !reset && hold;
        hz.ifid_flush  = !reset && !hold && !stall && hz.branch_taken;
        hz.op1_fwd     = reset ? 2'b00 : sel(hz.id_use_rs1, ex1, m1, wb1);
        hz.op2_fwd     = reset ? 2'b00 : sel(hz.id_use_rs2, ex2, m2, wb2);
        hz.r0_fwd      = reset ? 2'b00 : sel(hz.id_use_r0, exr, mr, wbr);
        hz.md_busy     = !reset && state == MD_BUSY;
        hz.md_count    = count;
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: vector table plus multi-cycle sequences, checked through an expected-output queue.
module tb_hazard_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    hazard_controller_if hz();
    hazard_controller #(.MD_CYCLES(4)) dut (.clk(clk), .reset(reset), .hz(hz.slave));
    typedef struct packed {
        logic [3:0] rs1, rs2;
        logic       u1, u2, ur0, br;
        logic [3:0] exrd, mrd, wbrd;
        logic [1:0] exrw, mrw, wbrw;
        logic       exmr, mmr, exmd;
    } in_t;
    typedef struct packed {
        logic       pcw, ifw, idw, fl, idb, exb;
        logic [1:0] f1, f2, fr;
        logic       bsy;
        logic [3:0] cnt;
    } out_t;
    typedef struct {
        string nm;
        in_t   i;
        out_t  e;
    } vec_t;
    typedef struct {
        string nm;
        out_t  e;
        out_t  m;
    } exp_t;
    exp_t sb[$];
    vec_t tbl[$];
    int checks = 0;
    int errors = 0;
    out_t act;
    assign act = {hz.pc_write, hz.ifid_write, hz.idex_write, hz.ifid_flush, hz.idex_bubble,
                  hz.exm_bubble, hz.op1_fwd, hz.op2_fwd, hz.r0_fwd, hz.md_busy, hz.md_count};
    function automatic out_t o(logic pcw, logic ifw, logic idw, logic fl, logic idb, logic exb,
                               logic [1:0] a, logic [1:0] b, logic [1:0] r, logic bsy, logic [3:0] c);
        return {pcw, ifw, idw, fl, idb, exb, a, b, r, bsy, c};
    endfunction
    function automatic out_t nrm(logic [1:0] a, logic [1:0] b, logic [1:0] r, logic bsy = 1'b0, logic [3:0] c = 4'd0);
        return o(1, 1, 1, 0, 0, 0, a, b, r, bsy, c);
    endfunction
    function automatic out_t stl(logic [1:0] a, logic [1:0] b, logic [1:0] r);
        return o(0, 0, 1, 0, 1, 0, a, b, r, 0, 4'd0);
    endfunction
    function automatic out_t hld(logic [1:0] a, logic bsy, logic [3:0] c);
        return o(0, 0, 0, 0, 0, 1, a, 2'b00, 2'b00, bsy, c);
    endfunction
    task automatic drv(input in_t i);
        hz.id_rs1 = i.rs1; hz.id_rs2 = i.rs2;
        hz.id_use_rs1 = i.u1; hz.id_use_rs2 = i.u2; hz.id_use_r0 = i.ur0; hz.branch_taken = i.br;
        hz.ex_rd = i.exrd; hz.m_rd = i.mrd; hz.wb_rd = i.wbrd;
        hz.ex_reg_write = i.exrw; hz.m_reg_write = i.mrw; hz.wb_reg_write = i.wbrw;
        hz.ex_mem_read = i.exmr; hz.m_mem_read = i.mmr; hz.ex_multidiv = i.exmd;
    endtask
    // Expectation is queued as stimulus is applied and retired mid-cycle, then the clock edge advances state.
    task automatic step(input string nm, input out_t e, input out_t m = '1);
        exp_t x;
        sb.push_back('{nm, e, m});
        @(negedge clk);
        x = sb.pop_front();
        checks++;
        if (((act ^ x.e) & x.m) != '0) begin
            errors++;
            $display("FAIL %s: got %h expected %h (mask %h)", x.nm, act, x.e, x.m);
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        in_t fw, ld, md, nz;
        fw = in_t'{rs1: 4'd3, rs2: 4'd3, u1: 1'b1, u2: 1'b1, exrd: 4'd3, mrd: 4'd3, wbrd: 4'd3,
                   exrw: 2'b01, mrw: 2'b01, wbrw: 2'b01, default: '0};
        tbl.push_back('{"fwd_ex", fw, nrm(2'b01, 2'b01, 2'b00)});
        fw.exrw = 2'b00;
        tbl.push_back('{"fwd_m", fw, nrm(2'b10, 2'b10, 2'b00)});
        fw.mrw = 2'b00;
        tbl.push_back('{"fwd_wb", fw, nrm(2'b11, 2'b11, 2'b00)});
        fw.wbrw = 2'b00;
        tbl.push_back('{"fwd_none", fw, nrm(2'b00, 2'b00, 2'b00)});
        tbl.push_back('{"fwd_unused", in_t'{rs1: 4'd3, rs2: 4'd3, exrd: 4'd3, exrw: 2'b01, default: '0},
                       nrm(2'b00, 2'b00, 2'b00)});
        tbl.push_back('{"fwd_split", in_t'{rs1: 4'd2, rs2: 4'd6, u1: 1'b1, u2: 1'b1, exrd: 4'd6, mrd: 4'd2,
                       exrw: 2'b01, mrw: 2'b01, default: '0}, nrm(2'b10, 2'b01, 2'b00)});
        tbl.push_back('{"r0_m", in_t'{ur0: 1'b1, exrd: 4'd5, mrd: 4'd7, exrw: 2'b01, mrw: 2'b10, default: '0},
                       nrm(2'b00, 2'b00, 2'b10)});
        tbl.push_back('{"r0_ex", in_t'{ur0: 1'b1, exrd: 4'd0, mrd: 4'd7, exrw: 2'b01, mrw: 2'b10, default: '0},
                       nrm(2'b00, 2'b00, 2'b01)});
        tbl.push_back('{"r0_wb", in_t'{ur0: 1'b1, wbrd: 4'd9, wbrw: 2'b10, default: '0}, nrm(2'b00, 2'b00, 2'b11)});
        tbl.push_back('{"r0_unused", in_t'{exrw: 2'b10, default: '0}, nrm(2'b00, 2'b00, 2'b00)});
        tbl.push_back('{"branch", in_t'{br: 1'b1, default: '0}, o(1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'd0)});
        tbl.push_back('{"stall_rs2_m", in_t'{rs2: 4'd8, u2: 1'b1, mrd: 4'd8, mrw: 2'b01, mmr: 1'b1, default: '0},
                       stl(2'b00, 2'b10, 2'b00)});
        tbl.push_back('{"no_stall_unused", in_t'{rs1: 4'd4, exrd: 4'd4, exrw: 2'b01, exmr: 1'b1, default: '0},
                       nrm(2'b00, 2'b00, 2'b00)});
        drv(in_t'{rs1: 4'd1, u1: 1'b1, ur0: 1'b1, br: 1'b1, exrd: 4'd1, exrw: 2'b11, exmr: 1'b1, exmd: 1'b1, default: '0});
        @(posedge clk);
        #1;
        step("reset", nrm(2'b00, 2'b00, 2'b00));
        reset = 1'b0;
        foreach (tbl[k]) begin
            drv(tbl[k].i);
            step(tbl[k].nm, tbl[k].e);
        end
        ld = in_t'{rs1: 4'd4, u1: 1'b1, exrd: 4'd4, exrw: 2'b01, exmr: 1'b1, default: '0};
        drv(ld);
        step("lu_ex", stl(2'b01, 2'b00, 2'b00));
        drv(in_t'{rs1: 4'd4, u1: 1'b1, mrd: 4'd4, mrw: 2'b01, mmr: 1'b1, default: '0});
        step("lu_m", stl(2'b10, 2'b00, 2'b00));
        drv(in_t'{rs1: 4'd4, u1: 1'b1, wbrd: 4'd4, wbrw: 2'b01, default: '0});
        step("lu_wb", nrm(2'b11, 2'b00, 2'b00));
        ld.br = 1'b1;
        drv(ld);
        step("br_in_stall", stl(2'b01, 2'b00, 2'b00));
        drv(in_t'{br: 1'b1, rs1: 4'd4, u1: 1'b1, wbrd: 4'd4, wbrw: 2'b01, default: '0});
        step("br_after_stall", o(1, 1, 1, 1, 0, 0, 2'b11, 2'b00, 2'b00, 0, 4'd0));
        md = in_t'{exmd: 1'b1, default: '0};
        nz = in_t'{exmd: 1'b1, br: 1'b1, rs1: 4'd4, u1: 1'b1, mrd: 4'd4, mrw: 2'b01, mmr: 1'b1, default: '0};
        drv(nz);
        step("md_entry", hld(2'b10, 0, 4'd0));
        step("md_busy2", hld(2'b10, 1, 4'd2));
        drv(md);
        step("md_busy1", hld(2'b00, 1, 4'd1));
        step("md_release", nrm(2'b00, 2'b00, 2'b00, 1, 4'd0));
        step("md2_entry", hld(2'b00, 0, 4'd0));
        step("md2_busy2", hld(2'b00, 1, 4'd2));
        step("md2_busy1", hld(2'b00, 1, 4'd1));
        step("md2_release", nrm(2'b00, 2'b00, 2'b00, 1, 4'd0));
        drv('0);
        step("md_done", nrm(2'b00, 2'b00, 2'b00));
        drv(md);
        step("rmd_entry", hld(2'b00, 0, 4'd0));
        step("rmd_busy2", hld(2'b00, 1, 4'd2));
        reset = 1'b1;
        drv(in_t'{exmd: 1'b1, rs1: 4'd2, u1: 1'b1, exrd: 4'd2, exrw: 2'b01, default: '0});
        step("rst_in_busy", nrm(2'b00, 2'b00, 2'b00), ~out_t'(17'h0000f));
        reset = 1'b0;
        drv(in_t'{rs1: 4'd2, u1: 1'b1, exrd: 4'd2, exrw: 2'b01, default: '0});
        step("rst_after", nrm(2'b01, 2'b00, 2'b00));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
